// File: rtl/mm_loop_sched_if.sv
// Instruction and MAC command bundle for mm_loop_sched.
// The master side is the scheduler; the slave side is the fetch controller plus datapath.
interface mm_loop_sched_if #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 16
);
  logic [DIM_W-1:0]  inst_m;
  logic [DIM_W-1:0]  inst_n;
  logic [DIM_W-1:0]  inst_p;
  logic              inst_valid;
  logic              inst_ready;
  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] op_a_addr;
  logic [ADDR_W-1:0] op_b_addr;
  logic [ADDR_W-1:0] op_c_addr;
  logic              op_first;
  logic              op_last;
  logic              busy;
  logic              done;

  modport master (
    input  inst_m, inst_n, inst_p, inst_valid, op_ready,
    output inst_ready, op_valid, op_a_addr, op_b_addr, op_c_addr,
           op_first, op_last, busy, done
  );

  modport slave (
    output inst_m, inst_n, inst_p, inst_valid, op_ready,
    input  inst_ready, op_valid, op_a_addr, op_b_addr, op_c_addr,
           op_first, op_last, busy, done
  );
endinterface

// File: rtl/mm_loop_sched.sv
// Expands one matrix-multiply instruction into i/j/k-ordered MAC address commands.
// Addresses are tracked incrementally (no multipliers) alongside the loop counters.
module mm_loop_sched #(
  parameter int              DIM_W  = 16,
  parameter int              ADDR_W = 16,
  parameter logic [ADDR_W-1:0] A_BASE = '0,
  parameter logic [ADDR_W-1:0] B_BASE = 16'h4000,
  parameter logic [ADDR_W-1:0] C_BASE = 16'h8000
) (
  input  logic             clk,
  input  logic             rst,
  mm_loop_sched_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DIM_W-1:0]  m_reg, m_next;
  logic [DIM_W-1:0]  n_reg, n_next;
  logic [DIM_W-1:0]  p_reg, p_next;
  logic [DIM_W-1:0]  i_reg, i_next;
  logic [DIM_W-1:0]  j_reg, j_next;
  logic [DIM_W-1:0]  k_reg, k_next;
  logic [ADDR_W-1:0] a_addr_reg, a_addr_next;
  logic [ADDR_W-1:0] a_row_reg, a_row_next;
  logic [ADDR_W-1:0] b_addr_reg, b_addr_next;
  logic [ADDR_W-1:0] c_addr_reg, c_addr_next;

  logic k_last, j_last, i_last, dims_nonzero;

  assign k_last = (k_reg == n_reg - DIM_W'(1));
  assign j_last = (j_reg == p_reg - DIM_W'(1));
  assign i_last = (i_reg == m_reg - DIM_W'(1));
  assign dims_nonzero = (bus.inst_m != '0) && (bus.inst_n != '0) && (bus.inst_p != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      m_reg      <= '0;
      n_reg      <= '0;
      p_reg      <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      a_addr_reg <= A_BASE;
      a_row_reg  <= A_BASE;
      b_addr_reg <= B_BASE;
      c_addr_reg <= C_BASE;
    end else begin
      state_reg  <= state_next;
      m_reg      <= m_next;
      n_reg      <= n_next;
      p_reg      <= p_next;
      i_reg      <= i_next;
      j_reg      <= j_next;
      k_reg      <= k_next;
      a_addr_reg <= a_addr_next;
      a_row_reg  <= a_row_next;
      b_addr_reg <= b_addr_next;
      c_addr_reg <= c_addr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    m_next      = m_reg;
    n_next      = n_reg;
    p_next      = p_reg;
    i_next      = i_reg;
    j_next      = j_reg;
    k_next      = k_reg;
    a_addr_next = a_addr_reg;
    a_row_next  = a_row_reg;
    b_addr_next = b_addr_reg;
    c_addr_next = c_addr_reg;

    case (state_reg)
      IDLE: begin
        if (bus.inst_valid) begin
          m_next      = bus.inst_m;
          n_next      = bus.inst_n;
          p_next      = bus.inst_p;
          i_next      = '0;
          j_next      = '0;
          k_next      = '0;
          a_addr_next = A_BASE;
          a_row_next  = A_BASE;
          b_addr_next = B_BASE;
          c_addr_next = C_BASE;
          state_next  = dims_nonzero ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.op_ready) begin
          if (!k_last) begin
            k_next      = k_reg + DIM_W'(1);
            a_addr_next = a_addr_reg + ADDR_W'(1);
            b_addr_next = b_addr_reg + ADDR_W'(p_reg);
          end else begin
            k_next      = '0;
            c_addr_next = c_addr_reg + ADDR_W'(1);
            if (!j_last) begin
              // Rewind A to the current row; B moves to the top of the next column.
              j_next      = j_reg + DIM_W'(1);
              a_addr_next = a_row_reg;
              b_addr_next = B_BASE + ADDR_W'(j_reg) + ADDR_W'(1);
            end else begin
              j_next      = '0;
              i_next      = i_reg + DIM_W'(1);
              a_row_next  = a_row_reg + ADDR_W'(n_reg);
              a_addr_next = a_row_reg + ADDR_W'(n_reg);
              b_addr_next = B_BASE;
              if (i_last) begin
                state_next = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.inst_ready = (state_reg == IDLE);
  assign bus.op_valid   = (state_reg == RUN);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.op_a_addr  = a_addr_reg;
  assign bus.op_b_addr  = b_addr_reg;
  assign bus.op_c_addr  = c_addr_reg;
  assign bus.op_first   = (k_reg == '0);
  assign bus.op_last    = k_last;

endmodule

// File: tb/tb_mm_loop_sched.sv
// Self-checking bench for mm_loop_sched: directed and random instructions
// compared against nested-loop address arithmetic.
module tb_mm_loop_sched;

  localparam int A_BASE = 0;
  localparam int B_BASE = 'h4000;
  localparam int C_BASE = 'h8000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] e_a[$];
  logic [15:0] e_b[$];
  logic [15:0] e_c[$];
  logic        e_f[$];
  logic        e_l[$];

  mm_loop_sched_if #(.DIM_W(16), .ADDR_W(16)) bus ();

  mm_loop_sched #(
    .DIM_W(16), .ADDR_W(16),
    .A_BASE(16'h0000), .B_BASE(16'h4000), .C_BASE(16'h8000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input int m, input int n, input int p);
    e_a.delete(); e_b.delete(); e_c.delete(); e_f.delete(); e_l.delete();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < p; j++)
        for (int k = 0; k < n; k++) begin
          e_a.push_back(16'(A_BASE + i * n + k));
          e_b.push_back(16'(B_BASE + k * p + j));
          e_c.push_back(16'(C_BASE + i * p + j));
          e_f.push_back(k == 0);
          e_l.push_back(k == n - 1);
        end
  endtask

  // mode: 0 = op_ready always high, 1 = random, 2 = pattern 0,0,1
  task automatic run_inst(input int m, input int n, input int p, input int mode,
                          input int abort_after, input bit hold,
                          input int hm, input int hn, input int hp);
    int  total;
    int  idx;
    int  sent;
    bit  fin;
    bit  rdy;
    build_model(m, n, p);
    total = e_a.size();
    bus.inst_m = 16'(m);
    bus.inst_n = 16'(n);
    bus.inst_p = 16'(p);
    bus.inst_valid = 1'b1;
    check("inst_ready_idle", 32'(bus.inst_ready), 1);
    @(posedge clk);
    #1;
    if (hold) begin
      bus.inst_m = 16'(hm);
      bus.inst_n = 16'(hn);
      bus.inst_p = 16'(hp);
    end else begin
      bus.inst_valid = 1'b0;
      bus.inst_m = 16'($urandom);
      bus.inst_n = 16'($urandom);
      bus.inst_p = 16'($urandom);
    end
    idx = 0;
    sent = 0;
    fin = 1'b0;
    if (total == 0) begin
      @(negedge clk);
      check("zero_done", 32'(bus.done), 1);
      check("zero_busy", 32'(bus.busy), 1);
      check("zero_op_valid", 32'(bus.op_valid), 0);
      check("zero_inst_ready", 32'(bus.inst_ready), 0);
      @(negedge clk);
      check("zero_done_end", 32'(bus.done), 0);
      check("zero_busy_end", 32'(bus.busy), 0);
      check("zero_ready_end", 32'(bus.inst_ready), 1);
    end else begin
      for (int cyc = 0; cyc < 4 * total + 20 && !fin; cyc++) begin
        @(negedge clk);
        if (idx < total && abort_after != 0 && idx == abort_after) begin
          #2 rst = 1'b1;
          #1;
          check("rst_op_valid", 32'(bus.op_valid), 0);
          check("rst_busy", 32'(bus.busy), 0);
          check("rst_done", 32'(bus.done), 0);
          check("rst_inst_ready", 32'(bus.inst_ready), 1);
          check("rst_a_addr", 32'(bus.op_a_addr), 32'(A_BASE));
          bus.op_ready = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("post_rst_done", 32'(bus.done), 0);
            check("post_rst_busy", 32'(bus.busy), 0);
          end
          fin = 1'b1;
        end else if (idx < total) begin
          check("op_valid", 32'(bus.op_valid), 1);
          check("run_done", 32'(bus.done), 0);
          check("run_inst_ready", 32'(bus.inst_ready), 0);
          check("a_addr", 32'(bus.op_a_addr), 32'(e_a[idx]));
          check("b_addr", 32'(bus.op_b_addr), 32'(e_b[idx]));
          check("c_addr", 32'(bus.op_c_addr), 32'(e_c[idx]));
          check("op_first", 32'(bus.op_first), 32'(e_f[idx]));
          check("op_last", 32'(bus.op_last), 32'(e_l[idx]));
          case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (sent % 3 == 2);
          endcase
          bus.op_ready = rdy;
          sent++;
          if (rdy) idx++;
        end else begin
          check("done_pulse", 32'(bus.done), 1);
          check("done_op_valid", 32'(bus.op_valid), 0);
          check("done_inst_ready", 32'(bus.inst_ready), 0);
          bus.op_ready = 1'(mode == 0);
          @(negedge clk);
          check("done_cleared", 32'(bus.done), 0);
          check("idle_busy", 32'(bus.busy), 0);
          check("idle_inst_ready", 32'(bus.inst_ready), 1);
          fin = 1'b1;
        end
      end
      if (!fin) check("timeout", 0, 1);
    end
    $display("inst m=%0d n=%0d p=%0d mode=%0d cmds=%0d/%0d cycles=%0d", m, n, p, mode,
             idx, total, sent);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.inst_m = '0;
    bus.inst_n = '0;
    bus.inst_p = '0;
    bus.inst_valid = 1'b0;
    bus.op_ready = 1'b0;
    #3;
    check("reset_op_valid", 32'(bus.op_valid), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_inst_ready", 32'(bus.inst_ready), 1);
    check("reset_a_addr", 32'(bus.op_a_addr), 32'(A_BASE));
    check("reset_b_addr", 32'(bus.op_b_addr), 32'(B_BASE));
    check("reset_c_addr", 32'(bus.op_c_addr), 32'(C_BASE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_inst(2, 3, 2, 0, 0, 1'b0, 0, 0, 0);
    run_inst(1, 1, 1, 2, 0, 1'b0, 0, 0, 0);
    run_inst(4, 0, 5, 0, 0, 1'b0, 0, 0, 0);
    // Second instruction is held on the inputs throughout the first.
    run_inst(2, 2, 3, 0, 0, 1'b1, 3, 1, 2);
    run_inst(3, 1, 2, 1, 0, 1'b0, 0, 0, 0);
    run_inst(3, 3, 3, 0, 7, 1'b0, 0, 0, 0);
    run_inst(2, 2, 2, 0, 0, 1'b0, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      run_inst(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 4)), 1, 0, 1'b0, 0, 0, 0);
    end
    run_inst(0, 2, 2, 1, 0, 1'b0, 0, 0, 0);
    run_inst(1, 4, 1, 2, 0, 1'b0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
